// File: rtl/device_unit_pkg.sv
// Shared types for the EX-stage device unit: FSM state encoding, the captured
// request bundle, default sizing and the effective-address helper.
package device_unit_pkg;

  localparam int DEF_MEM_ADDR_W = 20;
  localparam int DEF_UART_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_REQ  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_UART_RX  = 3'd3,
    ST_UART_TX  = 3'd4
  } dev_state_t;

  typedef struct packed {
    logic        wb;
    logic        uart;
    logic        neg;
    logic [7:0]  offset;
    logic [31:0] addr;
    logic [31:0] val;
    logic [7:0]  dest;
  } dev_req_t;

  // Word address = base +/- zero-extended offset, wrapping modulo 2^32.
  function automatic logic [31:0] calc_ea(input logic [31:0] addr,
                                          input logic [7:0]  offset,
                                          input logic        neg);
    if (neg) begin
      calc_ea = addr - {24'd0, offset};
    end else begin
      calc_ea = addr + {24'd0, offset};
    end
  endfunction

endpackage

// File: rtl/device_unit_uart_word_seq.sv
// uart_word_seq: byte counter plus word assemble/disassemble for UART word
// transfers, little-endian (byte 0 first). It knows nothing about the FIFO
// handshake: the caller pulses 'step' for every byte actually moved.
// Supports 1..4 bytes per word.
module uart_word_seq
  import device_unit_pkg::*;
#(
  parameter int BYTES = DEF_UART_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] load_word,
  input  logic        step,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  cur_byte,
  output logic [31:0] word_next,
  output logic        last
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

  logic [1:0]  cnt_r;
  logic [31:0] word_r;
  logic [4:0]  bit_idx_s;

  assign bit_idx_s = {cnt_r, 3'b000};
  assign last      = (cnt_r == LAST_IDX);
  assign cur_byte  = word_r[bit_idx_s +: 8];

  // Word as it will look after this cycle, with the incoming byte merged in.
  always_comb begin
    word_next = word_r;
    if (step) begin
      word_next[bit_idx_s +: 8] = rx_byte;
    end else begin
      word_next = word_r;
    end
  end

  // Counter and word register: start reloads the word and rewinds to byte 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (start) begin
      cnt_r  <= 2'd0;
      word_r <= load_word;
    end else if (step) begin
      word_r <= word_next;
      if (last) begin
        cnt_r <= 2'd0;
      end else begin
        cnt_r <= cnt_r + 2'd1;
      end
    end else begin
      cnt_r  <= cnt_r;
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/device_unit.sv
// device_unit: EX-stage device unit. Takes one request from decode at a time,
// runs a data-memory load/store or a UART word transfer, holds busy so decode
// stalls, and emits a single writeback pulse for loads and UART reads.
// Optional build macro DEVICE_STALL_CNT_EN adds a 32-bit busy-cycle counter
// output (stall_cnt).
module device_unit
  import device_unit_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int UART_BYTES = DEF_UART_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dev_en,
  input  logic                  dev_wb,
  input  logic                  dev_uart,
  input  logic                  dev_neg,
  input  logic [7:0]            dev_offset,
  input  logic [31:0]           dev_addr,
  input  logic [31:0]           dev_val,
  input  logic [7:0]            dev_dest,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_pop,
  input  logic                  tx_ready,
  output logic                  tx_push,
  output logic [7:0]            tx_data,
`ifdef DEVICE_STALL_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  output logic                  wb_en,
  output logic [7:0]            wb_dest,
  output logic [31:0]           wb_data
);

  dev_state_t  state_r;
  logic [7:0]  dest_r;
  dev_req_t    req_s;
  logic        capture_s;
  logic        seq_step_s;
  logic        seq_last_s;
  logic [7:0]  seq_byte_s;
  logic [31:0] seq_word_s;

  assign req_s = '{wb:     dev_wb,
                   uart:   dev_uart,
                   neg:    dev_neg,
                   offset: dev_offset,
                   addr:   dev_addr,
                   val:    dev_val,
                   dest:   dev_dest};

  assign capture_s = (state_r == ST_IDLE) && dev_en;

  // FIFO pop/push must act in the same cycle the byte is seen, so these
  // strobes are gated combinationally from registered state and the FIFO flag.
  assign rx_pop     = (state_r == ST_UART_RX) && rx_valid;
  assign tx_push    = (state_r == ST_UART_TX) && tx_ready;
  assign seq_step_s = rx_pop || tx_push;
  assign tx_data    = seq_byte_s;

  uart_word_seq #(
    .BYTES     (UART_BYTES)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (capture_s),
    .load_word (req_s.val),
    .step      (seq_step_s),
    .rx_byte   (rx_data),
    .cur_byte  (seq_byte_s),
    .word_next (seq_word_s),
    .last      (seq_last_s)
  );

  // Main control FSM with registered busy, memory request and writeback outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {MEM_ADDR_W{1'b0}};
      mem_wdata <= 32'd0;
      dest_r    <= 8'd0;
      wb_en     <= 1'b0;
      wb_dest   <= 8'd0;
      wb_data   <= 32'd0;
    end else begin
      wb_en <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            busy   <= 1'b1;
            dest_r <= req_s.dest;
            if (!req_s.uart) begin
              state_r   <= ST_MEM_REQ;
              mem_req   <= 1'b1;
              mem_we    <= !req_s.wb;
              mem_addr  <= MEM_ADDR_W'(calc_ea(req_s.addr, req_s.offset, req_s.neg));
              mem_wdata <= req_s.val;
            end else if (req_s.wb) begin
              state_r <= ST_UART_RX;
            end else begin
              state_r <= ST_UART_TX;
            end
          end
        end
        ST_MEM_REQ: begin
          // mem_we still carries the op direction while the request is up.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_rvalid) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            wb_en   <= 1'b1;
            wb_dest <= dest_r;
            wb_data <= mem_rdata;
          end
        end
        ST_UART_RX: begin
          if (rx_pop && seq_last_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            wb_en   <= 1'b1;
            wb_dest <= dest_r;
            wb_data <= seq_word_s;
          end
        end
        ST_UART_TX: begin
          if (tx_push && seq_last_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEVICE_STALL_CNT_EN
  // Busy-cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (busy) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_device_unit.sv
// Directed self-checking bench for device_unit. Inputs change just after the
// rising edge; outputs are sampled on the falling edge.
module tb_device_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_en, dev_wb, dev_uart, dev_neg;
  logic [7:0]  dev_offset, dev_dest;
  logic [31:0] dev_addr, dev_val;
  logic        busy, mem_req, mem_we;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rx_valid, rx_pop, tx_ready, tx_push;
  logic [7:0]  rx_data, tx_data;
  logic        wb_en;
  logic [7:0]  wb_dest;
  logic [31:0] wb_data;
`ifdef DEVICE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int compared = 0;
  int mismatched = 0;
  int wb_cnt = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  int busy_cyc = 0;

  always #5 clk = ~clk;

  device_unit dut (
    .clk(clk), .reset(reset),
    .dev_en(dev_en), .dev_wb(dev_wb), .dev_uart(dev_uart), .dev_neg(dev_neg),
    .dev_offset(dev_offset), .dev_addr(dev_addr), .dev_val(dev_val), .dev_dest(dev_dest),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
    .tx_ready(tx_ready), .tx_push(tx_push), .tx_data(tx_data),
`ifdef DEVICE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  // Pulse and busy-cycle tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (wb_en) wb_cnt = wb_cnt + 1;
    if (rx_pop) pop_cnt = pop_cnt + 1;
    if (tx_push) push_cnt = push_cnt + 1;
    if (reset) busy_cyc = 0;
    else if (busy) busy_cyc = busy_cyc + 1;
  end

  // Issue one request; call with the unit idle. Returns just after capture.
  task automatic issue(input logic uart, input logic wb, input logic neg,
                       input logic [7:0] off, input logic [31:0] addr,
                       input logic [31:0] val, input logic [7:0] dest);
    dev_uart = uart; dev_wb = wb; dev_neg = neg; dev_offset = off;
    dev_addr = addr; dev_val = val; dev_dest = dest; dev_en = 1'b1;
    @(posedge clk); #1;
    dev_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dev_en = 1'b0; dev_wb = 1'b0; dev_uart = 1'b0; dev_neg = 1'b0;
    dev_offset = 8'd0; dev_addr = 32'd0; dev_val = 32'd0; dev_dest = 8'd0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if ({busy, mem_req, mem_we, rx_pop, tx_push, wb_en} !== 6'd0) begin mismatched++; $display("FAIL reset_ctrl: got %b want 000000", {busy, mem_req, mem_we, rx_pop, tx_push, wb_en}); end
    compared++; if (mem_addr !== 20'd0 || mem_wdata !== 32'd0) begin mismatched++; $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    compared++; if (tx_data !== 8'd0 || wb_dest !== 8'd0 || wb_data !== 32'd0) begin mismatched++; $display("FAIL reset_data: got tx %h dest %h data %h want 0", tx_data, wb_dest, wb_data); end
`ifdef DEVICE_STALL_CNT_EN
    compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int w0;
    w0 = wb_cnt;
    issue(1'b0, 1'b0, 1'b0, 8'h04, 32'h0000_0100, 32'hDEAD_BEEF, 8'h11);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ack = 1'b1;
      @(negedge clk);
      compared++; if ({busy, mem_req, mem_we} !== 3'b111) begin mismatched++; $display("FAIL store_req[%0d]: got %b want 111", i, {busy, mem_req, mem_we}); end
      compared++; if (mem_addr !== 20'h00104 || mem_wdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL store_addr[%0d]: got %h/%h want 00104/deadbeef", i, mem_addr, mem_wdata); end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    compared++; if ({busy, mem_req, mem_we, wb_en} !== 4'b0000) begin mismatched++; $display("FAIL store_done: got %b want 0000", {busy, mem_req, mem_we, wb_en}); end
    @(posedge clk); #1;
    compared++; if (wb_cnt !== w0) begin mismatched++; $display("FAIL store_no_wb: got %0d want %0d", wb_cnt, w0); end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] addrs [2];
    logic [7:0]  offs [2];
    logic        negs [2];
    logic [19:0] exp [2];
    addrs = '{32'hFFFF_FFFE, 32'h0123_4567};
    offs  = '{8'h03, 8'hFF};
    negs  = '{1'b0, 1'b1};
    exp   = '{20'h00001, 20'h34468};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b0, negs[i], offs[i], addrs[i], 32'h0, 8'h0);
      mem_ack = 1'b1;
      @(negedge clk);
      compared++; if (mem_addr !== exp[i]) begin mismatched++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, mem_addr, exp[i]); end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_load();
    int w0;
    w0 = wb_cnt;
    issue(1'b0, 1'b1, 1'b1, 8'h10, 32'h0000_0010, 32'h0, 8'h5A);
    mem_ack = 1'b1;
    @(negedge clk);
    compared++; if ({busy, mem_req, mem_we} !== 3'b110 || mem_addr !== 20'h0) begin mismatched++; $display("FAIL load_req: got %b addr %h want 110 addr 00000", {busy, mem_req, mem_we}, mem_addr); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    compared++; if ({busy, mem_req} !== 2'b10) begin mismatched++; $display("FAIL load_wait: got %b want 10", {busy, mem_req}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    compared++; if ({busy, wb_en} !== 2'b10) begin mismatched++; $display("FAIL load_prewb: got %b want 10", {busy, wb_en}); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    compared++; if ({busy, wb_en} !== 2'b01) begin mismatched++; $display("FAIL load_wb: got %b want 01", {busy, wb_en}); end
    compared++; if (wb_data !== 32'h1234_5678 || wb_dest !== 8'h5A) begin mismatched++; $display("FAIL load_wbdata: got %h/%h want 12345678/5a", wb_data, wb_dest); end
    @(posedge clk); #1;
    @(negedge clk);
    compared++; if (wb_en !== 1'b0) begin mismatched++; $display("FAIL load_wbpulse: got %b want 0", wb_en); end
    @(posedge clk); #1;
    compared++; if (wb_cnt !== w0 + 1) begin mismatched++; $display("FAIL load_wbcnt: got %0d want %0d", wb_cnt, w0 + 1); end
  endtask

  task automatic test_uart_rx();
    logic [7:0] rxb [4];
    logic       pat [7];
    int idx, p0;
    rxb = '{8'h78, 8'h56, 8'h34, 8'h12};
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx = 0; p0 = pop_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'h0, 32'h0, 32'h0, 8'h33);
    for (int i = 0; i < 7; i++) begin
      rx_valid = pat[i];
      rx_data  = rxb[idx];
      @(negedge clk);
      compared++; if ({busy, rx_pop, wb_en} !== {1'b1, pat[i], 1'b0}) begin mismatched++; $display("FAIL rx_cycle[%0d]: got %b want %b", i, {busy, rx_pop, wb_en}, {1'b1, pat[i], 1'b0}); end
      if (pat[i]) idx++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; rx_data = 8'h0;
    @(negedge clk);
    compared++; if ({busy, rx_pop, wb_en} !== 3'b001) begin mismatched++; $display("FAIL rx_done: got %b want 001", {busy, rx_pop, wb_en}); end
    compared++; if (wb_data !== 32'h1234_5678 || wb_dest !== 8'h33) begin mismatched++; $display("FAIL rx_wbdata: got %h/%h want 12345678/33", wb_data, wb_dest); end
    @(posedge clk); #1;
    compared++; if (pop_cnt !== p0 + 4) begin mismatched++; $display("FAIL rx_pops: got %0d want %0d", pop_cnt - p0, 4); end
  endtask

  task automatic test_uart_tx();
    logic [7:0] expb [4];
    logic       pat [9];
    int idx, p0, w0;
    expb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    pat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    idx = 0; p0 = push_cnt; w0 = wb_cnt;
    issue(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 32'hA1B2_C3D4, 8'h0);
    for (int i = 0; i < 9; i++) begin
      tx_ready = pat[i];
      @(negedge clk);
      compared++; if ({busy, tx_push} !== {1'b1, pat[i]}) begin mismatched++; $display("FAIL tx_cycle[%0d]: got %b want %b", i, {busy, tx_push}, {1'b1, pat[i]}); end
      if (pat[i]) begin
        compared++; if (tx_data !== expb[idx]) begin mismatched++; $display("FAIL tx_byte[%0d]: got %h want %h", idx, tx_data, expb[idx]); end
        idx++;
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    @(negedge clk);
    compared++; if ({busy, tx_push, wb_en} !== 3'b000) begin mismatched++; $display("FAIL tx_done: got %b want 000", {busy, tx_push, wb_en}); end
    @(posedge clk); #1;
    compared++; if (push_cnt !== p0 + 4 || wb_cnt !== w0) begin mismatched++; $display("FAIL tx_counts: got push %0d wb %0d want 4 0", push_cnt - p0, wb_cnt - w0); end
  endtask

  task automatic test_reset_mid_rx();
    int w0;
    w0 = wb_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'h0, 32'h0, 32'h0, 8'h44);
    rx_valid = 1'b1; rx_data = 8'hAA;
    @(posedge clk); #1;
    rx_data = 8'hBB;
    @(posedge clk); #1;
    rx_data = 8'hCC;
    reset = 1'b1;
    #1;
    compared++; if ({busy, mem_req, mem_we, rx_pop, tx_push, wb_en} !== 6'd0) begin mismatched++; $display("FAIL midrst_ctrl: got %b want 000000", {busy, mem_req, mem_we, rx_pop, tx_push, wb_en}); end
    compared++; if (wb_data !== 32'd0 || tx_data !== 8'd0 || mem_addr !== 20'd0) begin mismatched++; $display("FAIL midrst_data: got %h/%h/%h want 0", wb_data, tx_data, mem_addr); end
    @(posedge clk); #1;
    reset = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    compared++; if ({busy, wb_en} !== 2'b00) begin mismatched++; $display("FAIL midrst_after: got %b want 00", {busy, wb_en}); end
    issue(1'b1, 1'b1, 1'b0, 8'h0, 32'h0, 32'h0, 8'h45);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(i + 1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    @(negedge clk);
    compared++; if (wb_en !== 1'b1 || wb_data !== 32'h0403_0201 || wb_dest !== 8'h45) begin mismatched++; $display("FAIL midrst_next: got %b %h %h want 1 04030201 45", wb_en, wb_data, wb_dest); end
    @(posedge clk); #1;
    compared++; if (wb_cnt !== w0 + 1) begin mismatched++; $display("FAIL midrst_wbcnt: got %0d want %0d", wb_cnt - w0, 1); end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 1'b0, 8'h01, 32'h0000_0200, 32'h0, 8'h77);
    // Stray request while busy: a store to a different address.
    dev_en = 1'b1; dev_wb = 1'b0; dev_uart = 1'b0; dev_addr = 32'h0000_0999; dev_val = 32'h1;
    @(negedge clk);
    compared++; if ({busy, mem_req, mem_we} !== 3'b110 || mem_addr !== 20'h00201) begin mismatched++; $display("FAIL b2b_load: got %b %h want 110 00201", {busy, mem_req, mem_we}, mem_addr); end
    @(posedge clk); #1;
    dev_en = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    compared++; if (mem_we !== 1'b0 || mem_addr !== 20'h00201) begin mismatched++; $display("FAIL b2b_ignore: got we %b addr %h want 0 00201", mem_we, mem_addr); end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    compared++; if ({busy, mem_req} !== 2'b10) begin mismatched++; $display("FAIL b2b_wait: got %b want 10", {busy, mem_req}); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    dev_en = 1'b1; dev_wb = 1'b0; dev_uart = 1'b0; dev_neg = 1'b1; dev_offset = 8'h02;
    dev_addr = 32'h0000_0300; dev_val = 32'h55AA_55AA; dev_dest = 8'h0;
    @(negedge clk);
    compared++; if ({busy, wb_en} !== 2'b01 || wb_data !== 32'hCAFE_F00D || wb_dest !== 8'h77) begin mismatched++; $display("FAIL b2b_wb: got %b %h %h want 01 cafef00d 77", {busy, wb_en}, wb_data, wb_dest); end
    @(posedge clk); #1;
    dev_en = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    compared++; if ({busy, mem_req, mem_we, wb_en} !== 4'b1110 || mem_addr !== 20'h002FE || mem_wdata !== 32'h55AA_55AA) begin mismatched++; $display("FAIL b2b_store: got %b %h %h want 1110 002fe 55aa55aa", {busy, mem_req, mem_we, wb_en}, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    compared++; if ({busy, mem_req} !== 2'b00) begin mismatched++; $display("FAIL b2b_done: got %b want 00", {busy, mem_req}); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_cnt();
    @(posedge clk); #1;
`ifdef DEVICE_STALL_CNT_EN
    compared++; if (stall_cnt !== 32'(busy_cyc)) begin mismatched++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, busy_cyc); end
`endif
  endtask

  initial begin
    test_reset();
    test_store();
    test_addr_wrap();
    test_load();
    test_uart_rx();
    test_uart_tx();
    test_reset_mid_rx();
    test_back_to_back();
    test_stall_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
